// File: rtl/bp_fe_instr_aligner.sv
// bp_fe_instr_aligner: buffers fetch packets as halfwords and emits one aligned RV64C instruction per cycle
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   flush_i             drop every buffered halfword (redirect)
//   fetch_data_i/pc_i   incoming packet and PC of its halfword 0 (or first valid halfword)
//   fetch_v_i/ready_o   packet handshake
//   instr_o/pc_o        head instruction (compressed ones zero-extended) and its PC
//   instr_compressed_o  head instruction is 16-bit
//   instr_v_o/yumi_i    instruction handshake
module bp_fe_instr_aligner #(
    parameter int fetch_width_p = 64,
    parameter int buf_hwords_p  = 8,
    parameter int vaddr_width_p = 39
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic [fetch_width_p-1:0] fetch_data_i,
    input  logic [vaddr_width_p-1:0] fetch_pc_i,
    input  logic                     fetch_v_i,
    output logic                     fetch_ready_o,
    output logic [31:0]              instr_o,
    output logic [vaddr_width_p-1:0] instr_pc_o,
    output logic                     instr_compressed_o,
    output logic                     instr_v_o,
    input  logic                     instr_yumi_i
);
    localparam int fetch_hwords = fetch_width_p / 16;
    localparam int ptr_w = $clog2(buf_hwords_p);
    localparam int cnt_w = $clog2(buf_hwords_p + 1);
    localparam int off_w = $clog2(fetch_width_p / 8) - 1;

    logic [15:0]              hw_buf [buf_hwords_p];
    logic [ptr_w-1:0]         rd_ptr, wr_ptr;
    logic [cnt_w-1:0]         count, enq_n, deq_n;
    logic [vaddr_width_p-1:0] head_pc;
    logic [off_w-1:0]         offset, shift;
    logic [fetch_width_p-1:0] shifted;
    logic [15:0]              hw0, hw1;
    logic                     empty, compressed, acc, deq;

    assign offset = fetch_pc_i[off_w:1];
    assign empty  = count == '0;
    // An unaligned start PC is only honoured into an empty buffer; otherwise the packet is sequential.
    assign shift   = empty ? offset : '0;
    assign shifted = fetch_data_i >> {shift, 4'b0};
    assign enq_n   = empty ? cnt_w'(fetch_hwords) - cnt_w'(offset) : cnt_w'(fetch_hwords);

    assign hw0        = hw_buf[rd_ptr];
    assign hw1        = hw_buf[rd_ptr + ptr_w'(1)];
    assign compressed = hw0[1:0] != 2'b11;
    assign deq_n      = compressed ? cnt_w'(1) : cnt_w'(2);

    // Readiness uses the start-of-cycle count only, so it never depends on instr_yumi_i.
    assign fetch_ready_o = ~flush_i & (int'(count) + fetch_hwords <= buf_hwords_p);
    // A lone 32-bit tail halfword waits for its upper half.
    assign instr_v_o     = ~flush_i & ((~empty & compressed) | (count >= cnt_w'(2)));

    assign acc = fetch_v_i & fetch_ready_o;
    assign deq = instr_yumi_i & instr_v_o;

    assign instr_o            = compressed ? {16'h0, hw0} : {hw1, hw0};
    assign instr_pc_o         = head_pc;
    assign instr_compressed_o = compressed & ~empty;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            head_pc <= '0;
            for (int k = 0; k < buf_hwords_p; k++) hw_buf[k] <= '0;
        end else if (flush_i) begin
            count  <= '0;
            rd_ptr <= wr_ptr;
        end else begin
            count   <= count + (acc ? enq_n : '0) - (deq ? deq_n : '0);
            wr_ptr  <= acc ? wr_ptr + ptr_w'(enq_n) : wr_ptr;
            rd_ptr  <= deq ? rd_ptr + ptr_w'(deq_n) : rd_ptr;
            head_pc <= (acc & empty) ? fetch_pc_i
                     : deq ? head_pc + (compressed ? vaddr_width_p'(2) : vaddr_width_p'(4))
                     : head_pc;
            for (int k = 0; k < fetch_hwords; k++)
                if (acc && k < int'(enq_n)) hw_buf[wr_ptr + ptr_w'(k)] <= shifted[16*k +: 16];
        end
    end
endmodule

// File: tb/tb_bp_fe_instr_aligner.sv
// tb_bp_fe_instr_aligner: directed self-checking bench for the instruction aligner
module tb_bp_fe_instr_aligner;
    logic        clk = 1'b0;
    logic        reset_i, flush_i, fetch_v_i, fetch_ready_o;
    logic [63:0] fetch_data_i;
    logic [38:0] fetch_pc_i, instr_pc_o;
    logic [31:0] instr_o;
    logic        instr_compressed_o, instr_v_o, instr_yumi_i;
    logic        take, force_yumi;
    int          n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    assign instr_yumi_i = force_yumi | (take & instr_v_o);

    bp_fe_instr_aligner dut (
        .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
        .fetch_data_i(fetch_data_i), .fetch_pc_i(fetch_pc_i), .fetch_v_i(fetch_v_i),
        .fetch_ready_o(fetch_ready_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .instr_compressed_o(instr_compressed_o), .instr_v_o(instr_v_o), .instr_yumi_i(instr_yumi_i)
    );

    always @(negedge clk)
        if (!reset_i && !flush_i)
            assert (!(instr_yumi_i && !instr_v_o)) else $error("yumi asserted without valid");

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_instr(input string tag, input logic [31:0] i, input logic [38:0] pc, input logic c);
        check({tag, ".v"}, 64'(instr_v_o), 64'd1);
        check({tag, ".instr"}, 64'(instr_o), 64'(i));
        check({tag, ".pc"}, 64'(instr_pc_o), 64'(pc));
        check({tag, ".c"}, 64'(instr_compressed_o), 64'(c));
    endtask

    task automatic fetch(input string tag, input logic [38:0] pc, input logic [63:0] data, input logic pre_v);
        fetch_v_i    = 1'b1;
        fetch_pc_i   = pc;
        fetch_data_i = data;
        #1;
        check({tag, ".ready"}, 64'(fetch_ready_o), 64'd1);
        check({tag, ".pre_v"}, 64'(instr_v_o), 64'(pre_v));
        cyc();
        fetch_v_i = 1'b0;
        #1;
    endtask

    task automatic idle_state(input string tag);
        check({tag, ".v"}, 64'(instr_v_o), 64'd0);
        check({tag, ".ready"}, 64'(fetch_ready_o), 64'd1);
        check({tag, ".pc"}, 64'(instr_pc_o), 64'd0);
        check({tag, ".instr"}, 64'(instr_o), 64'd0);
        check({tag, ".c"}, 64'(instr_compressed_o), 64'd0);
        check({tag, ".count"}, 64'(dut.count), 64'd0);
    endtask

    initial begin
        reset_i = 1'b1; flush_i = 1'b0; fetch_v_i = 1'b0; fetch_data_i = '0; fetch_pc_i = '0;
        take = 1'b0; force_yumi = 1'b0;
        cyc(); cyc();
        reset_i = 1'b0;
        #1;
        idle_state("reset");

        take = 1'b1;
        fetch("s2", 39'h80000000, 64'h0001_4501_00A0_0513, 1'b0);
        expect_instr("s2.i0", 32'h00A00513, 39'h80000000, 1'b0);
        cyc(); expect_instr("s2.i1", 32'h00004501, 39'h80000004, 1'b1);
        cyc(); expect_instr("s2.i2", 32'h00000001, 39'h80000006, 1'b1);
        cyc();
        check("s2.end_v", 64'(instr_v_o), 64'd0);
        check("s2.end_count", 64'(dut.count), 64'd0);

        fetch("s3a", 39'h80000000, 64'h0513_0001_0001_0001, 1'b0);
        expect_instr("s3.i0", 32'h00000001, 39'h80000000, 1'b1);
        cyc(); expect_instr("s3.i1", 32'h00000001, 39'h80000002, 1'b1);
        cyc(); expect_instr("s3.i2", 32'h00000001, 39'h80000004, 1'b1);
        cyc();
        check("s3.tail_v", 64'(instr_v_o), 64'd0);
        check("s3.tail_count", 64'(dut.count), 64'd1);
        fetch("s3b", 39'h80000008, 64'h0001_0001_0001_00A0, 1'b0);
        check("s3.count5", 64'(dut.count), 64'd5);
        check("s3.ready_at5", 64'(fetch_ready_o), 64'd0);
        expect_instr("s3.straddle", 32'h00A00513, 39'h80000006, 1'b0);
        cyc(); expect_instr("s3.after", 32'h00000001, 39'h8000000A, 1'b1);
        cyc(); cyc(); cyc();
        check("s3.end_v", 64'(instr_v_o), 64'd0);
        check("s3.end_count", 64'(dut.count), 64'd0);

        take = 1'b0;
        fetch("s4", 39'h80000004, 64'h0001_4501_DEAD_BEEF, 1'b0);
        check("s4.count", 64'(dut.count), 64'd2);
        expect_instr("s4.i0", 32'h00004501, 39'h80000004, 1'b1);
        take = 1'b1;
        cyc(); expect_instr("s4.i1", 32'h00000001, 39'h80000006, 1'b1);
        cyc();
        check("s4.end_v", 64'(instr_v_o), 64'd0);
        take = 1'b0;

        fetch("s5a", 39'h80000100, {32'h00B00593, 32'h00A00513}, 1'b0);
        check("s5.count4", 64'(dut.count), 64'd4);
        fetch("s5b", 39'h80000108, {32'h00D00693, 32'h00C00613}, 1'b1);
        check("s5.count8", 64'(dut.count), 64'd8);
        check("s5.full_ready", 64'(fetch_ready_o), 64'd0);
        take = 1'b1;
        #1;
        expect_instr("s5.i0", 32'h00A00513, 39'h80000100, 1'b0);
        cyc(); expect_instr("s5.i1", 32'h00B00593, 39'h80000104, 1'b0);
        check("s5.count6", 64'(dut.count), 64'd6);
        check("s5.ready6", 64'(fetch_ready_o), 64'd0);
        cyc(); expect_instr("s5.i2", 32'h00C00613, 39'h80000108, 1'b0);
        check("s5.ready4", 64'(fetch_ready_o), 64'd1);
        cyc(); expect_instr("s5.i3", 32'h00D00693, 39'h8000010C, 1'b0);
        cyc();
        check("s5.end_v", 64'(instr_v_o), 64'd0);
        take = 1'b0;

        fetch("s6a", 39'h80000204, {32'h00B00593, 32'hDEADBEEF}, 1'b0);
        fetch("s6b", 39'h80000208, {32'h00D00693, 32'h00C00613}, 1'b1);
        check("s6.count6", 64'(dut.count), 64'd6);
        flush_i = 1'b1; force_yumi = 1'b1;
        #1;
        check("s6.flush_v", 64'(instr_v_o), 64'd0);
        check("s6.flush_ready", 64'(fetch_ready_o), 64'd0);
        cyc();
        flush_i = 1'b0; force_yumi = 1'b0;
        #1;
        check("s6.post_count", 64'(dut.count), 64'd0);
        check("s6.post_v", 64'(instr_v_o), 64'd0);
        check("s6.post_ready", 64'(fetch_ready_o), 64'd1);
        fetch("s6c", 39'h80001000, 64'h0001_0001_00A0_0513, 1'b0);
        expect_instr("s6.redirect", 32'h00A00513, 39'h80001000, 1'b0);
        take = 1'b1;
        cyc(); expect_instr("s6.next", 32'h00000001, 39'h80001004, 1'b1);
        reset_i = 1'b1;
        cyc();
        reset_i = 1'b0; take = 1'b0;
        #1;
        idle_state("midreset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
